// File: rtl/exu_muldiv.sv
// RV64 M-extension multiply/divide unit: iterative shift-add multiply, restoring divide.
// Define EXU_FASTMUL_EN for a single-cycle combinational multiply path.
module exu_muldiv #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_pre_valid,
  output logic         o_pre_ready,
  output logic         o_post_valid,
  input  logic         i_post_ready,
  input  logic [2:0]   i_op,
  input  logic         i_word,
  input  logic [W-1:0] i_src1,
  input  logic [W-1:0] i_src2,
  output logic [W-1:0] o_result,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam int CW = $clog2(W + 1);

  function automatic logic [W-1:0] f_sext32(
    input logic [W-1:0] v
  );
    return {{(W-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [W-1:0] f_mulsel(
    input logic [2:0]     op,
    input logic           word,
    input logic [2*W-1:0] p
  );
    if (word) return f_sext32(p[W-1:0]);
    if (op[1:0] == 2'd0) return p[W-1:0];
    return p[2*W-1:W];
  endfunction

  state_t          r_state;
  logic            r_valid;
  logic            r_busy;
  logic [W-1:0]    r_result;
  logic [2:0]      r_op;
  logic            r_word;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [W-1:0]    r_a;
  logic [CW-1:0]   r_cnt;

  logic            w_div;
  logic            w_s1sgn;
  logic            w_s2sgn;
  logic [W-1:0]    w_x1;
  logic [W-1:0]    w_x2;
  logic            w_neg1;
  logic            w_neg2;
  logic [W-1:0]    w_mag1;
  logic [W-1:0]    w_mag2;
  logic            w_dz;
  logic            w_ovf;
  logic            w_skip;
  logic [W-1:0]    w_spec;
  logic [W-1:0]    w_spec_res;
  logic            w_fast;
  logic [W-1:0]    w_fres;

  assign w_div   = i_op[2];
  assign w_s1sgn = w_div ? ~i_op[0] : (i_op[1:0] != 2'd3);
  assign w_s2sgn = w_div ? ~i_op[0] : (i_op[1:0] <= 2'd1);

  assign w_x1 = !i_word ? i_src1 :
                w_s1sgn ? f_sext32(i_src1) :
                {{(W-32){1'b0}}, i_src1[31:0]};
  assign w_x2 = !i_word ? i_src2 :
                w_s2sgn ? f_sext32(i_src2) :
                {{(W-32){1'b0}}, i_src2[31:0]};

  assign w_neg1 = w_s1sgn & w_x1[W-1];
  assign w_neg2 = w_s2sgn & w_x2[W-1];
  assign w_mag1 = w_neg1 ? -w_x1 : w_x1;
  assign w_mag2 = w_neg2 ? -w_x2 : w_x2;

  // Most-negative / -1: word operands are already sign-extended here
  assign w_dz  = (w_x2 == '0);
  assign w_ovf = w_div & w_s1sgn & (w_x2 == '1) &
                 (i_word ? (w_x1[31:0] == 32'h8000_0000)
                         : (w_x1 == {1'b1, {(W-1){1'b0}}}));
  assign w_skip = w_div & (w_dz | w_ovf);

  assign w_spec = i_op[1] ? (w_dz ? w_x1 : '0)
                          : (w_dz ? '1 : w_x1);
  assign w_spec_res = i_word ? f_sext32(w_spec) : w_spec;

`ifdef EXU_FASTMUL_EN
  logic [2*W-1:0] w_fp;
  assign w_fp   = {{W{w_neg1}}, w_x1} * {{W{w_neg2}}, w_x2};
  assign w_fast = ~w_div;
  assign w_fres = f_mulsel(i_op, i_word, w_fp);
`else
  assign w_fast = 1'b0;
  assign w_fres = '0;
`endif

  logic [W:0]      w_sum;
  logic [W:0]      w_rs;
  logic [W:0]      w_diff;
  logic            w_ge;
  logic [W-1:0]    w_n_hi;
  logic [W-1:0]    w_n_lo;

  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_rs   = {r_hi, r_lo[W-1]};
    w_diff = w_rs - {1'b0, r_a};
    w_ge   = ~w_diff[W];
    if (r_op[2]) begin
      w_n_hi = w_ge ? w_diff[W-1:0] : w_rs[W-1:0];
      w_n_lo = {r_lo[W-2:0], w_ge};
    end else begin
      w_n_hi = w_sum[W:1];
      w_n_lo = {w_sum[0], r_lo[W-1:1]};
    end
  end

  logic [2*W-1:0]  w_p;
  logic [2*W-1:0]  w_pn;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_mres;
  logic [W-1:0]    w_q;
  logic [W-1:0]    w_r;
  logic [W-1:0]    w_dsel;
  logic [W-1:0]    w_dres;
  logic [W-1:0]    w_fin;

  // Word multiplies run N=32 steps, leaving the product shifted up by W-32
  assign w_p    = {w_n_hi, w_n_lo};
  assign w_pn   = r_neg_q ? -w_p : w_p;
  assign w_prod = r_word ? (w_pn >> (W - 32)) : w_pn;
  assign w_mres = f_mulsel(r_op, r_word, w_prod);

  assign w_q    = r_neg_q ? -w_n_lo : w_n_lo;
  assign w_r    = r_neg_r ? -w_n_hi : w_n_hi;
  assign w_dsel = r_op[1] ? w_r : w_q;
  assign w_dres = r_word ? f_sext32(w_dsel) : w_dsel;
  assign w_fin  = r_op[2] ? w_dres : w_mres;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_pre_valid) begin
            r_op    <= i_op;
            r_word  <= i_word;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_hi    <= '0;
            r_lo    <= !w_div ? w_mag2 :
                       i_word ? (w_mag1 << (W - 32)) : w_mag1;
            r_a     <= w_div ? w_mag2 : w_mag1;
            r_cnt   <= i_word ? CW'(32) : CW'(W);
            r_busy  <= 1'b1;
            unique case (1'b1)
              w_skip: begin
                r_state  <= S_DONE;
                r_valid  <= 1'b1;
                r_result <= w_spec_res;
              end
              w_fast: begin
                r_state  <= S_DONE;
                r_valid  <= 1'b1;
                r_result <= w_fres;
              end
              default: r_state <= S_CALC;
            endcase
          end
        end
        S_CALC: begin
          r_hi  <= w_n_hi;
          r_lo  <= w_n_lo;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
            r_result <= w_fin;
          end
        end
        S_DONE: begin
          if (i_post_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pre_ready  = (r_state == S_IDLE);
  assign o_post_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_result     = r_result;

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv: directed M-extension vectors, random ops,
// flush and reset abort. Latency expectations follow EXU_FASTMUL_EN.
module tb_exu_muldiv;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        pre_valid;
  logic        pre_ready;
  logic        post_valid;
  logic        post_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  exp_t sb[$];

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  exu_muldiv #(.W(64)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_pre_valid  (pre_valid),
    .o_pre_ready  (pre_ready),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .i_op         (op),
    .i_word       (word),
    .i_src1       (src1),
    .i_src2       (src2),
    .o_result     (result),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]       ea, eb, p;
    logic [31:0]        ua, ub, r32, l32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    ua = a[31:0]; ub = b[31:0];
    sa32 = a[31:0]; sb32 = b[31:0];
    sa = a; sb = b;
    if (!o[2]) begin
      ea = (o[1:0] != 2'd3 && a[63]) ? {ONES, a} : {64'd0, a};
      eb = (o[1:0] <= 2'd1 && b[63]) ? {ONES, b} : {64'd0, b};
      p = ea * eb;
      l32 = ua * ub;
      if (w) return sx(l32);
      return (o[1:0] == 2'd0) ? p[63:0] : p[127:64];
    end
    if (w) begin
      if (ub == 32'd0) r32 = o[1] ? ua : 32'hFFFF_FFFF;
      else if (!o[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF)
        r32 = o[1] ? 32'd0 : 32'h8000_0000;
      else if (!o[0]) r32 = o[1] ? sa32 % sb32 : sa32 / sb32;
      else r32 = o[1] ? ua % ub : ua / ub;
      return sx(r32);
    end
    if (b == 64'd0) return o[1] ? a : ONES;
    if (!o[0] && a == MIN64 && b == ONES) return o[1] ? 64'd0 : MIN64;
    if (!o[0]) return o[1] ? sa % sb : sa / sb;
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic w,
                                input logic [63:0] a, input logic [63:0] b);
    logic dz, ovf;
    if (!o[2]) begin
`ifdef EXU_FASTMUL_EN
      return 1;
`else
      return w ? 33 : 65;
`endif
    end
    dz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == MIN64 && b == ONES));
    if (dz || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  task automatic issue(input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!pre_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(pre_ready), 64'd1);
    op = o; word = w; src1 = a; src2 = b;
    pre_valid = 1'b1;
    @(posedge clk);
    #1;
    pre_valid = 1'b0;
    op   = 3'($urandom);
    word = 1'($urandom);
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask

  task automatic collect(input string tag, input int hold);
    int   lat = 0;
    exp_t e;
    do begin
      @(negedge clk);
      lat++;
    end while (!post_valid && lat < 300);
    e = sb.pop_front();
    chk({tag, "_res"}, result, e.res);
    chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, 64'(post_valid), 64'd1);
      chk({tag, "_hold_r"}, result, e.res);
    end
    post_ready = 1'b1;
    @(negedge clk);
    post_ready = 1'b0;
    chk({tag, "_rdy"}, 64'(pre_ready), 64'd1);
    chk({tag, "_vdrop"}, 64'(post_valid), 64'd0);
  endtask

  task automatic run_x(input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int hold,
                       input string tag);
    exp_t e;
    e.res = exp;
    e.lat = lat_of(o, w, a, b);
    sb.push_back(e);
    issue(o, w, a, b);
    collect(tag, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;
    rst_n = 1'b0; flush = 1'b0; pre_valid = 1'b0; post_ready = 1'b0;
    op = 3'd0; word = 1'b0; src1 = '0; src2 = '0;
    #12;
    chk("rst_valid", 64'(post_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(pre_ready), 64'd1);

    run_x(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 0, "divu");
    run_x(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 0, "remu");
    run_x(3'd4, 1'b0, MIN64, ONES, MIN64, 0, "div_ovf");
    run_x(3'd6, 1'b0, MIN64, ONES, 64'd0, 0, "rem_ovf");
    run_x(3'd4, 1'b1, -64'sd7, 64'd0, ONES, 0, "divw_dz");
    run_x(3'd6, 1'b1, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 0, "remw_dz");
    run_x(3'd1, 1'b0, -64'sd2, 64'd3, ONES, 5, "mulh");
    run_x(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulhu");
    run_x(3'd2, 1'b0, ONES, 64'd2, ONES, 0, "mulhsu");
    run_x(3'd4, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, "div_neg");
    run_x(3'd6, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, "rem_neg");
    run_x(3'd5, 1'b0, 64'd5, 64'd0, ONES, 0, "divu_dz");
    run_x(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 0, "remu_dz");
    run_x(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00,
          0, "mul");

    issue(3'd5, 1'b0, 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    chk("flush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(pre_ready), 64'd1);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (post_valid) seen = 1;
    end
    chk("flush_novalid", 64'(seen), 64'd0);
    run_x(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulw");

    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom);
      rw = 1'($urandom);
      if (!ro[2] && rw) ro = 3'd0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_x(ro, rw, ra, rb, model(ro, rw, ra, rb), 0, "rand");
    end

    issue(3'd5, 1'b0, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    chk("rcalc_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rcalc_busy", 64'(busy), 64'd0);
    chk("rcalc_valid", 64'(post_valid), 64'd0);
    chk("rcalc_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rcalc_ready", 64'(pre_ready), 64'd1);

    issue(3'd5, 1'b0, 64'd9, 64'd0);
    @(negedge clk);
    chk("rdone_valid_pre", 64'(post_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rdone_valid", 64'(post_valid), 64'd0);
    chk("rdone_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdone_ready", 64'(pre_ready), 64'd1);
    chk("rdone_busy", 64'(busy), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
